// File: rtl/bg_pixel_fifo_if.sv
// Background pixel FIFO <-> tile fetcher handshake.
//   push_valid_in  : fetcher row valid (driven by the fetcher)
//   push_pixels_in : DEPTH 2-bit color indices, element 0 is the leftmost pixel
//   empty_out      : FIFO holds no pixels (driven by the FIFO)
// Modports: master = fetcher side, slave = FIFO side.
interface bg_pixel_fifo_if #(
  parameter int DEPTH = 8
);
  logic                  push_valid_in;
  logic [DEPTH-1:0][1:0] push_pixels_in;
  logic                  empty_out;

  modport master (
    output push_valid_in,
    output push_pixels_in,
    input  empty_out
  );

  modport slave (
    input  push_valid_in,
    input  push_pixels_in,
    output empty_out
  );
endinterface

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO sitting between the background tile fetcher and the
// LCD output stage. Accepts whole 8-pixel rows, drops the SCX fine-scroll
// pixels at the start of a line, then shifts one pixel per T-cycle out with a
// running X position and an end-of-line pulse.
//
// Ports:
//   clk_in, rst_in (sync, active high), tclk_in (T-cycle enable)
//   line_start_in, flush_in, stall_in, SCX_in[7:0] (bits [2:0] used)
//   push_if (slave)   : push_valid_in, push_pixels_in, empty_out
//   pixel_valid_out, pixel_out[1:0], X_out, line_done_out, overflow_out
//
// Optional build macro BG_PIXEL_FIFO_PALETTE_EN: adds BGP_in[7:0] and maps each
// output color index through it; otherwise pixel_out is the raw index.
//
// state   | meaning
// IDLE    | no popping, waiting for line_start_in
// DISCARD | popping SCX&7 fine-scroll pixels without output
// SHIFT   | popping visible pixels, X advancing
// DONE    | last visible pixel sent; pulse line_done_out, back to IDLE
module bg_pixel_fifo #(
  parameter int X_MAX = 160,
  parameter int DEPTH = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         tclk_in,
  input  logic                         line_start_in,
  input  logic                         flush_in,
  input  logic                         stall_in,
  input  logic [7:0]                   SCX_in,
`ifdef BG_PIXEL_FIFO_PALETTE_EN
  input  logic [7:0]                   BGP_in,
`endif
  bg_pixel_fifo_if.slave               push_if,
  output logic                         pixel_valid_out,
  output logic [1:0]                   pixel_out,
  output logic [$clog2(X_MAX+1)-1:0]   X_out,
  output logic                         line_done_out,
  output logic                         overflow_out
);

  localparam int XW = $clog2(X_MAX+1);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DISCARD = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH-1:0][1:0] store_q, store_d;
  logic [2:0]            disc_q, disc_d;
  logic [XW-1:0]         x_q, x_d;
  logic                  pix_vld_q, pix_vld_d;
  logic [1:0]            pix_q, pix_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  push_ok, pop_en;
  logic [1:0]            color;

  // Only the fine-scroll bits of SCX matter here.
  logic unused_scx;
  assign unused_scx = ^SCX_in[7:3];

`ifdef BG_PIXEL_FIFO_PALETTE_EN
  assign color = BGP_in[{store_q[0], 1'b0} +: 2];
`else
  assign color = store_q[0];
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    store_d   = store_q;
    disc_d    = disc_q;
    x_d       = x_q;
    pix_vld_d = 1'b0;
    pix_d     = pix_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    push_ok   = 1'b0;
    pop_en    = 1'b0;

    if (tclk_in) begin
      if (line_start_in) begin
        // New line wins over everything; a same-edge push is dropped.
        count_d = '0;
        x_d     = '0;
        disc_d  = SCX_in[2:0];
        state_d = (SCX_in[2:0] != 3'd0) ? DISCARD : SHIFT;
      end else begin
        // Flush empties the FIFO before the push is considered.
        push_ok = push_if.push_valid_in && ((count_q == '0) || flush_in);
        pop_en  = ((state_q == DISCARD) || (state_q == SHIFT)) &&
                  (count_q != '0) && !stall_in && !flush_in;

        if (push_if.push_valid_in && !push_ok)
          ovf_d = 1'b1;

        if (push_ok) begin
          store_d = push_if.push_pixels_in;
          count_d = CW'(DEPTH);
        end else if (flush_in) begin
          count_d = '0;
        end else if (pop_en) begin
          for (int i = 0; i < DEPTH-1; i++)
            store_d[i] = store_q[i+1];
          store_d[DEPTH-1] = 2'd0;
          count_d = count_q - 1'b1;
        end

        case (state_q)
          DISCARD: begin
            if (pop_en) begin
              disc_d = disc_q - 3'd1;
              if (disc_q == 3'd1)
                state_d = SHIFT;
            end
          end
          SHIFT: begin
            if (pop_en) begin
              pix_vld_d = 1'b1;
              pix_d     = color;
              x_d       = x_q + 1'b1;
              if (x_q == XW'(X_MAX-1))
                state_d = DONE;
            end
          end
          DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      count_q   <= '0;
      store_q   <= '0;
      disc_q    <= '0;
      x_q       <= '0;
      pix_vld_q <= 1'b0;
      pix_q     <= 2'd0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      store_q   <= store_d;
      disc_q    <= disc_d;
      x_q       <= x_d;
      pix_vld_q <= pix_vld_d;
      pix_q     <= pix_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign push_if.empty_out = (count_q == '0);
  assign pixel_valid_out   = pix_vld_q;
  assign pixel_out         = pix_q;
  assign X_out             = x_q;
  assign line_done_out     = done_q;
  assign overflow_out      = ovf_q;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
module tb_bg_pixel_fifo;

  typedef logic [7:0][1:0] row_t;

  typedef struct {
    logic       ls, fl, st, tc, pv;
    row_t       px;
    logic [2:0] scx;
    logic       e_empty, e_pv;
    logic [1:0] e_pix;
    logic [7:0] e_x;
    logic       e_ld, e_ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, tclk, line_start, flush, stall;
  logic [7:0] scx;
  logic       pix_vld, line_done, ovf;
  logic [1:0] pix;
  logic [7:0] x_pos;

  int n_chk  = 0;
  int n_fail = 0;

  bg_pixel_fifo_if #(.DEPTH(8)) fifo_if ();

  bg_pixel_fifo #(.X_MAX(160), .DEPTH(8)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .tclk_in         (tclk),
    .line_start_in   (line_start),
    .flush_in        (flush),
    .stall_in        (stall),
    .SCX_in          (scx),
    .push_if         (fifo_if.slave),
    .pixel_valid_out (pix_vld),
    .pixel_out       (pix),
    .X_out           (x_pos),
    .line_done_out   (line_done),
    .overflow_out    (ovf)
  );

  always #5 clk = ~clk;

  function automatic row_t row(input int a, b, c, d, e, f, g, h);
    row_t r;
    r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(d);
    r[4] = 2'(e); r[5] = 2'(f); r[6] = 2'(g); r[7] = 2'(h);
    return r;
  endfunction

  function automatic vec_t mk(input int ls, fl, pv, input row_t px, input int s,
                              input int e_empty, e_pv, e_pix, e_x, e_ov);
    vec_t v;
    v.ls = 1'(ls); v.fl = 1'(fl); v.st = 1'b0; v.tc = 1'b1; v.pv = 1'(pv);
    v.px = px; v.scx = 3'(s);
    v.e_empty = 1'(e_empty); v.e_pv = 1'(e_pv); v.e_pix = 2'(e_pix);
    v.e_x = 8'(e_x); v.e_ld = 1'b0; v.e_ov = 1'(e_ov);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ls, fl, st, tc, pv, input row_t px, input logic [7:0] s);
    line_start = ls; flush = fl; stall = st; tclk = tc;
    fifo_if.push_valid_in = pv; fifo_if.push_pixels_in = px; scx = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 1, 0, '0, 8'd0);
  endtask

  vec_t vt[$];
  int   pa[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int   pv_cnt, ld_cnt;

  initial begin
    row_t ra, rb, rc, rd, re, rf, rg, rh, ri;
    ra = row(0, 1, 2, 3, 3, 2, 1, 0);
    rb = row(3, 2, 1, 0, 1, 2, 3, 0);
    rc = row(1, 1, 1, 1, 2, 2, 2, 2);
    rd = row(3, 3, 3, 3, 3, 3, 3, 3);
    re = row(0, 0, 0, 0, 3, 3, 3, 3);
    rf = row(1, 2, 3, 1, 2, 3, 1, 2);
    rg = row(0, 1, 2, 3, 0, 1, 2, 3);
    rh = row(2, 1, 0, 3, 2, 1, 0, 3);

    // SCX=0 line, one row straight through
    vt.push_back(mk(1, 0, 0, '0, 0,  1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, ra, 0,  0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 0, '0, 0,  (i == 7), 1, pa[i], i + 1, 0));
    vt.push_back(mk(0, 0, 0, '0, 0,  1, 0, 0, 8, 0));
    // SCX=5: five pixels discarded, then 2,3,0
    vt.push_back(mk(1, 0, 0, '0, 5,  1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, rb, 0,  0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0, 0, 0, '0, 0,  0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 3, 2, 0));
    vt.push_back(mk(0, 0, 0, '0, 0,  1, 1, 0, 3, 0));
    vt.push_back(mk(0, 0, 0, '0, 0,  1, 0, 0, 3, 0));
    // overflow: push with count=4 dropped, pop still happens, contents kept
    vt.push_back(mk(0, 0, 1, rc, 0,  0, 0, 0, 3, 0));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 1, 4 + i, 0));
    vt.push_back(mk(0, 0, 1, rd, 0,  0, 1, 2, 8, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 2, 9, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 2, 10, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  1, 1, 2, 11, 1));
    // flush + push on the same edge: accepted, no pop, no new overflow
    vt.push_back(mk(0, 0, 1, re, 0,  0, 0, 2, 11, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 0, 12, 1));
    vt.push_back(mk(0, 1, 1, rf, 0,  0, 0, 0, 12, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 1, 13, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 2, 14, 1));
    vt.push_back(mk(0, 0, 0, '0, 0,  0, 1, 3, 15, 1));

    rst = 1'b1;
    idle_in();
    fifo_if.push_pixels_in = '0;
    step(); step();
    chk("rst_empty", fifo_if.empty_out, 1);
    chk("rst_pv",    pix_vld, 0);
    chk("rst_pix",   pix, 0);
    chk("rst_x",     x_pos, 0);
    chk("rst_ld",    line_done, 0);
    chk("rst_ov",    ovf, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].ls, vt[i].fl, vt[i].st, vt[i].tc, vt[i].pv, vt[i].px, {5'd0, vt[i].scx});
      step();
      chk($sformatf("v%0d_empty", i), fifo_if.empty_out, vt[i].e_empty);
      chk($sformatf("v%0d_pv", i),    pix_vld,   vt[i].e_pv);
      chk($sformatf("v%0d_x", i),     x_pos,     vt[i].e_x);
      chk($sformatf("v%0d_ld", i),    line_done, vt[i].e_ld);
      chk($sformatf("v%0d_ov", i),    ovf,       vt[i].e_ov);
      if (vt[i].e_pv) chk($sformatf("v%0d_pix", i), pix, vt[i].e_pix);
      else if (i > 0) chk($sformatf("v%0d_pixhold", i), pix, vt[i].e_pix);
    end

    // tclk gating and stall mid-row
    drive(1, 0, 0, 1, 0, '0, 8'd0); step();
    drive(0, 0, 0, 1, 1, rg, 8'd0); step();
    idle_in(); step(); step();
    chk("stl_pre_x", x_pos, 2);
    chk("stl_pre_pix", pix, 1);
    tclk = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("tc0_%0d_pv", i), pix_vld, 0);
      chk($sformatf("tc0_%0d_x", i), x_pos, 2);
    end
    drive(0, 0, 1, 1, 0, '0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("stl%0d_pv", i), pix_vld, 0);
      chk($sformatf("stl%0d_x", i), x_pos, 2);
    end
    idle_in(); step();
    chk("stl_rel_pv", pix_vld, 1);
    chk("stl_rel_pix", pix, 2);
    chk("stl_rel_x", x_pos, 3);

    // full 160-pixel line from 20 rows
    drive(1, 0, 0, 1, 0, '0, 8'd0); step();
    chk("ln_start_x", x_pos, 0);
    chk("ln_start_empty", fifo_if.empty_out, 1);
    pv_cnt = 0; ld_cnt = 0;
    for (int r = 0; r < 20; r++) begin
      ri = row(r & 3, (r + 1) & 3, (r + 2) & 3, (r + 3) & 3,
               (r + 4) & 3, (r + 5) & 3, (r + 6) & 3, (r + 7) & 3);
      drive(0, 0, 0, 1, 1, ri, 8'd0); step();
      if (line_done) ld_cnt++;
      idle_in();
      for (int i = 0; i < 8; i++) begin
        step();
        if (line_done) ld_cnt++;
        if (pix_vld) begin
          pv_cnt++;
          if (pix != 2'((r + i) & 3))
            chk($sformatf("ln_r%0d_p%0d", r, i), pix, (r + i) & 3);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (line_done) ld_cnt++;
      if (pix_vld) pv_cnt++;
    end
    chk("ln_pv_cnt", pv_cnt, 160);
    chk("ln_ld_cnt", ld_cnt, 1);
    chk("ln_x_end", x_pos, 160);
    drive(0, 0, 0, 1, 1, rh, 8'd0); step();
    idle_in();
    pv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pix_vld) pv_cnt++;
    end
    chk("idle_no_pop", pv_cnt, 0);
    chk("idle_kept", fifo_if.empty_out, 0);
    chk("idle_x", x_pos, 160);
    drive(1, 0, 0, 1, 0, '0, 8'd0); step();
    chk("ln2_x", x_pos, 0);
    chk("ln2_empty", fifo_if.empty_out, 1);

    // reset mid-row with overflow set and pix=3
    drive(0, 0, 0, 1, 1, rd, 8'd0); step();
    idle_in(); step(); step(); step();
    drive(0, 0, 0, 1, 1, rg, 8'd0); step();
    chk("mr_pre_ov", ovf, 1);
    chk("mr_pre_pix", pix, 3);
    idle_in();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_empty", fifo_if.empty_out, 1);
    chk("mr_pv",    pix_vld, 0);
    chk("mr_pix",   pix, 0);
    chk("mr_x",     x_pos, 0);
    chk("mr_ld",    line_done, 0);
    chk("mr_ov",    ovf, 0);
    drive(1, 0, 0, 1, 0, '0, 8'd0); step();
    drive(0, 0, 0, 1, 1, rh, 8'd0); step();
    idle_in(); step();
    chk("mr_new_pv",  pix_vld, 1);
    chk("mr_new_pix", pix, 2);
    chk("mr_new_x",   x_pos, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_pixel_fifo.md
Name: bg_pixel_fifo

Overview:
- Background pixel FIFO, directly downstream of the background tile fetcher.
- Accepts 8-pixel tile rows from the fetcher and reports empty back to it.
- Discards the SCX fine-scroll pixels (SCX & 7) at the start of each line.
- Shifts one pixel per T-cycle toward the LCD output stage, with a running X position and an end-of-line pulse.

Parameters:
- X_MAX, 160, visible pixels per scanline; line ends after this many output pixels.
- DEPTH, 8, FIFO capacity in pixels; one fetcher row.

Ports:
- clk_in  input  1  system clock; all state updates on posedge.
- rst_in  input  1  synchronous, active-high reset.
- tclk_in  input  1  T-cycle enable strobe; push and pop act only on clk_in edges where tclk_in=1.
- line_start_in  input  1  start-of-scanline (mode 3 entry) pulse.
- flush_in  input  1  clear FIFO contents, e.g. on window start; X and state kept.
- stall_in  input  1  pause popping, e.g. during a sprite fetch.
- SCX_in  input  8  scroll X register; only bits [2:0] are used.
- push_valid_in  input  1  fetcher pixel row valid.
- push_pixels_in  input  2x8  color indices; index 0 is the leftmost pixel.
- empty_out  output  1  FIFO holds 0 pixels; feeds the fetcher's bg_fifo_empty_in.
- pixel_valid_out  output  1  one clk pulse per output pixel.
- pixel_out  output  2  output pixel value.
- X_out  output  $clog2(X_MAX+1)  index of the next pixel to output.
- line_done_out  output  1  one clk pulse after pixel X_MAX-1 is output.
- overflow_out  output  1  sticky error flag: push arrived while the FIFO was non-empty.

Behaviour:
- Reset values:
  - count=0, empty_out=1.
  - pixel_valid_out=0, pixel_out=0.
  - X_out=0, line_done_out=0, overflow_out=0.
  - State IDLE, discard counter 0, storage all 0.
- States:
  - IDLE: no popping. line_start_in -> DISCARD if SCX[2:0]!=0, else SHIFT.
  - DISCARD: each tclk edge with count>0 and !stall_in pops one pixel with no output and decrements the discard counter. When the counter reaches 0 -> SHIFT.
  - SHIFT: each tclk edge with count>0 and !stall_in pops one pixel and increments X. On the pop of pixel X_MAX-1 -> DONE.
  - DONE: pulse line_done_out for 1 clk, then -> IDLE.
- line_start_in:
  - Accepted in any state and has priority over all else.
  - Clears count, sets X=0, loads the discard counter with SCX[2:0], enters DISCARD or SHIFT per the IDLE rule.
  - A push on the same edge is dropped.
- Push:
  - Accepted on a tclk edge when push_valid_in=1 and count==0 before the edge.
  - Loads all 8 pixels and sets count=8.
  - A push when count!=0 is dropped and sets overflow_out (cleared only by reset).
  - No pop occurs on the same edge as an accepted push; the first pop is on the next tclk edge.
- Pop:
  - Removes index 0, shifts the rest down, count-1.
  - Stalled when count==0 or stall_in=1; X holds.
- Output timing:
  - pixel_valid_out and pixel_out are registered, valid the clk after the popping edge.
  - pixel_valid_out is high for exactly one clk; pixel_out holds its value until the next output pop.
- flush_in:
  - Sets count=0.
  - On the same edge as a push, the flush applies first and then the push is accepted (count=8, no overflow).
  - A pop on a flush edge is suppressed.
- empty_out is combinational from count (count==0).
- X_out never exceeds X_MAX. Pixels pushed after DONE/IDLE stay stored until the next line_start_in clears them.
- tclk_in=0: all state holds; pulse outputs still return to 0 after their one clk.

Optional Feature:
- Macro: BG_PIXEL_FIFO_PALETTE_EN.
- When defined:
  - Adds input BGP_in [7:0].
  - pixel_out = BGP_in[2*idx+1 : 2*idx] for popped color index idx, using BGP_in sampled at the pop edge.
- When undefined:
  - No BGP_in port.
  - pixel_out is the raw color index.

Test Plan:
- Reset, SCX=0, line_start, push row {0,1,2,3,3,2,1,0}, tclk every clk -> pixel_out sequence 0,1,2,3,3,2,1,0; X_out=8; empty_out=1 after 8 pops.
- SCX=5, line_start, push {3,2,1,0,1,2,3,0} -> first 5 pixels discarded with no pixel_valid_out; outputs 2,3,0; X_out=3.
- Second push while count=4 -> dropped, overflow_out=1, contents unchanged; simultaneous flush+push -> count=8, overflow_out unchanged.
- stall_in high 6 tclk mid-row -> no pops, X_out frozen; resumes from the same pixel after release.
- Feed 20 rows, SCX=0 -> exactly 160 pixel_valid_out pulses, line_done_out one pulse, state IDLE, X_out=160; line_start_in then resets X_out=0.
- Reset asserted mid-row -> all outputs at reset values next clk; line_start_in after reset behaves as a fresh line.
